fetch_unit: RTL and testbench

- Instruction-fetch front end that feeds decode.
- Turns the single system clock into the one-hot four-phase enables clk1..clk4 (Q1..Q4) consumed by decode and downstream stages.
- Owns the program counter and the program-memory read, and loads inst_reg at each instruction-cycle boundary.
- Two-stage fetch/execute overlap: while instruction n executes, instruction n+1 is fetched; a taken branch flushes the prefetched word with a NOP.

---
 rtl/pic_pkg.sv | 14 +
 rtl/fetch_unit_phase_gen.sv | 55 +++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the fetch front end and decode.
// Phase encoding, the injected NOP word, and the branch opcode class.
package pic_pkg;

   typedef enum logic [1:0] {Q1, Q2, Q3, Q4} phase_t;

   localparam logic [7:0] NOP_INST         = 8'h00;
   localparam logic [1:0] OPC_CLASS_BRANCH = 2'b10;

   function automatic logic is_branch_class(input logic [7:0] inst);
      return inst[7:6] == OPC_CLASS_BRANCH;
   endfunction

endpackage

// File: rtl/fetch_unit_phase_gen.sv
// Four-phase generator: turns clk into one-hot enables Q1..Q4.
// Phase only advances once running and while not stalled.
module phase_gen
   import pic_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   stall,
   output logic   run,
   output phase_t phase,
   output logic   clk1,
   output logic   clk2,
   output logic   clk3,
   output logic   clk4
);

   logic   run_q, run_d;
   phase_t phase_q, phase_d;
   logic   active;

   // NOTE: every variable driven here gets a default first, so no latch is inferred.
   always_comb begin
      run_d   = 1'b1;
      phase_d = phase_q;
      if (run_q && !stall) begin
         unique case (phase_q)
            Q1: phase_d = Q2;
            Q2: phase_d = Q3;
            Q3: phase_d = Q4;
            Q4: phase_d = Q1;
            default: phase_d = Q1;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         phase_q <= Q1;
      end else begin
         run_q   <= run_d;
         phase_q <= phase_d;
      end
   end

   assign active = run_q && !stall;
   assign run    = run_q;
   assign phase  = phase_q;
   assign clk1   = active && (phase_q == Q1);
   assign clk2   = active && (phase_q == Q2);
   assign clk3   = active && (phase_q == Q3);
   assign clk4   = active && (phase_q == Q4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, program-memory read, inst_reg and branch flush.
// Optional skip-next support is built when FETCH_SKIP_EN is defined.
module fetch_unit
   import pic_pkg::*;
#(
   parameter int PC_W      = 8,
   parameter int RESET_VEC = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            branch_en,
   input  logic [PC_W-1:0] branch_addr,
   input  logic            skip,
   output logic [PC_W-1:0] pmem_addr,
   output logic            pmem_rd,
   input  logic [7:0]      pmem_data,
   output logic            clk1,
   output logic            clk2,
   output logic            clk3,
   output logic            clk4,
   output logic [7:0]      inst_reg,
   output logic [PC_W-1:0] pc,
   output logic            flush
);

   logic   run;
   phase_t phase;
   logic   advance;

   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      inst_q, inst_d;
   logic            flush_q, flush_d;
   logic [7:0]      fbuf_q, fbuf_d;
   logic            br_pend_q, br_pend_d;
   logic [PC_W-1:0] br_addr_q, br_addr_d;
`ifdef FETCH_SKIP_EN
   logic            skip_pend_q, skip_pend_d;
`else
   logic            skip_unused;
   assign skip_unused = skip;
`endif

   phase_gen u_phase_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .run   (run),
      .phase (phase),
      .clk1  (clk1),
      .clk2  (clk2),
      .clk3  (clk3),
      .clk4  (clk4)
   );

   assign advance = run && !stall;

   always_comb begin
      pc_d      = pc_q;
      inst_d    = inst_q;
      flush_d   = flush_q;
      fbuf_d    = fbuf_q;
      br_pend_d = br_pend_q;
      br_addr_d = br_addr_q;
`ifdef FETCH_SKIP_EN
      skip_pend_d = skip_pend_q;
`endif
      if (advance) begin
         unique case (phase)
            Q2: fbuf_d = pmem_data;
            Q3: begin
               // An injected NOP cannot branch.
               br_pend_d = branch_en && !flush_q;
               br_addr_d = branch_addr;
`ifdef FETCH_SKIP_EN
               skip_pend_d = skip;
`endif
            end
            Q4: begin
               br_pend_d = 1'b0;
`ifdef FETCH_SKIP_EN
               skip_pend_d = 1'b0;
`endif
               if (br_pend_q) begin
                  pc_d    = br_addr_q;
                  inst_d  = NOP_INST;
                  flush_d = 1'b1;
`ifdef FETCH_SKIP_EN
               end else if (skip_pend_q) begin
                  pc_d    = pc_q + PC_W'(1);
                  inst_d  = NOP_INST;
                  flush_d = 1'b1;
`endif
               end else begin
                  pc_d    = pc_q + PC_W'(1);
                  inst_d  = fbuf_q;
                  flush_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the fetch buffer is a single register, not a memory, so it takes a reset value too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= PC_W'(RESET_VEC);
         inst_q    <= NOP_INST;
         flush_q   <= 1'b1;
         fbuf_q    <= 8'h00;
         br_pend_q <= 1'b0;
         br_addr_q <= '0;
`ifdef FETCH_SKIP_EN
         skip_pend_q <= 1'b0;
`endif
      end else begin
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         flush_q   <= flush_d;
         fbuf_q    <= fbuf_d;
         br_pend_q <= br_pend_d;
         br_addr_q <= br_addr_d;
`ifdef FETCH_SKIP_EN
         skip_pend_q <= skip_pend_d;
`endif
      end
   end

   assign pmem_rd   = clk1;
   assign pmem_addr = pc_q;
   assign pc        = pc_q;
   assign inst_reg  = inst_q;
   assign flush     = flush_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction-level reference model with
// randomized memory contents and branch traffic; a PC_W=4 instance covers wrap.
module tb_fetch_unit;

`ifdef FETCH_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0;
   logic       branch_en = 1'b0;
   logic [7:0] branch_addr = 8'h00;
   logic       skip = 1'b0;
   logic [7:0] pmem_addr, pmem_data = 8'h00, inst_reg, pc;
   logic       pmem_rd, clk1, clk2, clk3, clk4, flush;

   logic [3:0] pmem_addr4, pc4;
   logic [7:0] pmem_data4 = 8'h00, inst4;
   logic       pmem_rd4, c4_1, c4_2, c4_3, c4_4, flush4;

   logic [7:0] mem  [256];
   logic [7:0] mem4 [16];

   int pass_cnt = 0;
   int total_cnt = 0;

   int         exp_pc, exp4_pc;
   logic [7:0] exp_inst, exp4_inst;
   logic       exp_flush, exp4_flush;
   bit         chk4 = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(.PC_W(8), .RESET_VEC(0)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_en(branch_en),
      .branch_addr(branch_addr), .skip(skip), .pmem_addr(pmem_addr),
      .pmem_rd(pmem_rd), .pmem_data(pmem_data), .clk1(clk1), .clk2(clk2),
      .clk3(clk3), .clk4(clk4), .inst_reg(inst_reg), .pc(pc), .flush(flush)
   );

   fetch_unit #(.PC_W(4), .RESET_VEC(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .stall(1'b0), .branch_en(1'b0),
      .branch_addr(4'h0), .skip(1'b0), .pmem_addr(pmem_addr4),
      .pmem_rd(pmem_rd4), .pmem_data(pmem_data4), .clk1(c4_1), .clk2(c4_2),
      .clk3(c4_3), .clk4(c4_4), .inst_reg(inst4), .pc(pc4), .flush(flush4)
   );

   // Program memories with one-cycle read latency.
   always @(posedge clk) begin
      if (pmem_rd)  pmem_data  <= mem[pmem_addr];
      if (pmem_rd4) pmem_data4 <= mem4[pmem_addr4];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_init();
      exp_pc     = 0;
      exp_inst   = 8'h00;
      exp_flush  = 1'b1;
      exp4_pc    = 0;
      exp4_inst  = 8'h00;
      exp4_flush = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 1'b0;
      branch_en = 1'b0;
      skip = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      model_init();
   endtask

   // One full instruction cycle Q1..Q4, starting with the DUT in Q1.
   task automatic instr_cycle(input int br_phase, input logic [7:0] br_addr,
                              input int stall_phase, input bit do_skip);
      logic [3:0] exp_oh;
      bit taken, skipped;
      taken   = (br_phase == 3) && !exp_flush;
      skipped = SKIP_EN && do_skip && !taken;
      for (int k = 1; k <= 4; k++) begin
         if (k == stall_phase) begin
            stall = 1'b1;
            #1;
            for (int s = 0; s < 5; s++) begin
               total_cnt++;
               if ({clk1, clk2, clk3, clk4, pmem_rd} !== 5'b0 || pc !== 8'(exp_pc) || inst_reg !== exp_inst) begin
                  $display("FAIL stall_hold: got en=%b pc=%h inst=%h expected en=00000 pc=%h inst=%h",
                           {clk1, clk2, clk3, clk4, pmem_rd}, pc, inst_reg, 8'(exp_pc), exp_inst);
               end else pass_cnt++;
               tick();
            end
            stall = 1'b0;
            #1;
         end
         exp_oh = 4'b1000 >> (k - 1);
         total_cnt++;
         if ({clk1, clk2, clk3, clk4} !== exp_oh || pmem_rd !== (k == 1)) begin
            $display("FAIL phase_Q%0d: got clk1..4=%b rd=%b expected %b rd=%b",
                     k, {clk1, clk2, clk3, clk4}, pmem_rd, exp_oh, (k == 1));
         end else pass_cnt++;
         if (k == 1) begin
            total_cnt++;
            if (pmem_addr !== 8'(exp_pc)) begin
               $display("FAIL pmem_addr: got %h expected %h", pmem_addr, 8'(exp_pc));
            end else pass_cnt++;
         end
         branch_en   = (k == br_phase);
         branch_addr = br_addr;
         skip        = do_skip && (k == 3);
         tick();
      end
      branch_en = 1'b0;
      skip = 1'b0;

      if (taken) begin
         exp_inst = 8'h00; exp_flush = 1'b1; exp_pc = br_addr;
      end else if (skipped) begin
         exp_inst = 8'h00; exp_flush = 1'b1; exp_pc = (exp_pc + 1) % 256;
      end else begin
         exp_inst = mem[exp_pc]; exp_flush = 1'b0; exp_pc = (exp_pc + 1) % 256;
      end
      exp4_inst  = mem4[exp4_pc];
      exp4_flush = 1'b0;
      exp4_pc    = (exp4_pc + 1) % 16;

      total_cnt++;
      if (inst_reg !== exp_inst || flush !== exp_flush || pc !== 8'(exp_pc)) begin
         $display("FAIL boundary: got inst=%h flush=%b pc=%h expected inst=%h flush=%b pc=%h",
                  inst_reg, flush, pc, exp_inst, exp_flush, 8'(exp_pc));
      end else pass_cnt++;
      if (chk4) begin
         total_cnt++;
         if (inst4 !== exp4_inst || flush4 !== exp4_flush || pc4 !== 4'(exp4_pc)) begin
            $display("FAIL wrap_pc4: got inst=%h flush=%b pc=%h expected inst=%h flush=%b pc=%h",
                     inst4, flush4, pc4, exp4_inst, exp4_flush, 4'(exp4_pc));
         end else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if ({clk1, clk2, clk3, clk4, pmem_rd} !== 5'b0 || pc !== 8'h00 || inst_reg !== 8'h00 || flush !== 1'b1) begin
         $display("FAIL reset_values: got en=%b pc=%h inst=%h flush=%b expected en=00000 pc=00 inst=00 flush=1",
                  {clk1, clk2, clk3, clk4, pmem_rd}, pc, inst_reg, flush);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      model_init();
      total_cnt++;
      if (clk1 !== 1'b1 || flush !== 1'b1 || inst_reg !== 8'h00) begin
         $display("FAIL startup_q1: got clk1=%b flush=%b inst=%h expected clk1=1 flush=1 inst=00",
                  clk1, flush, inst_reg);
      end else pass_cnt++;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
      apply_reset();
      repeat (3) instr_cycle(0, 8'h00, 0, 1'b0);
   endtask

   task automatic test_pc_wrap();
      for (int i = 0; i < 16; i++) mem4[i] = 8'(i + 8'h10);
      apply_reset();
      chk4 = 1'b1;
      repeat (17) instr_cycle(0, 8'h00, 0, 1'b0);
      chk4 = 1'b0;
      total_cnt++;
      if (pc4 !== 4'h1 || inst4 !== 8'h10) begin
         $display("FAIL pc_wrap_end: got pc4=%h inst4=%h expected pc4=1 inst4=10", pc4, inst4);
      end else pass_cnt++;
   endtask

   task automatic test_branch();
      apply_reset();
      repeat (3) instr_cycle(0, 8'h00, 0, 1'b0);
      instr_cycle(3, 8'h40, 0, 1'b0);
      total_cnt++;
      if (inst_reg !== 8'h00 || flush !== 1'b1 || pmem_addr !== 8'h40) begin
         $display("FAIL branch_nop: got inst=%h flush=%b addr=%h expected inst=00 flush=1 addr=40",
                  inst_reg, flush, pmem_addr);
      end else pass_cnt++;
      instr_cycle(0, 8'h00, 0, 1'b0);
      total_cnt++;
      if (inst_reg !== mem[8'h40]) begin
         $display("FAIL branch_target: got %h expected %h", inst_reg, mem[8'h40]);
      end else pass_cnt++;
   endtask

   task automatic test_branch_other_phases();
      apply_reset();
      instr_cycle(0, 8'h00, 0, 1'b0);
      instr_cycle(1, 8'h77, 0, 1'b0);
      instr_cycle(2, 8'h88, 0, 1'b0);
      instr_cycle(4, 8'h99, 0, 1'b0);
      instr_cycle(0, 8'h00, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      instr_cycle(3, 8'h20, 0, 1'b0);
      instr_cycle(3, 8'h30, 0, 1'b0);
      instr_cycle(3, 8'h50, 0, 1'b0);
      instr_cycle(3, 8'hA0, 0, 1'b0);
      instr_cycle(0, 8'h00, 0, 1'b0);
   endtask

   task automatic test_stall();
      apply_reset();
      repeat (2) instr_cycle(0, 8'h00, 0, 1'b0);
      instr_cycle(0, 8'h00, 2, 1'b0);
      instr_cycle(3, 8'h33, 3, 1'b0);
      repeat (2) instr_cycle(0, 8'h00, 0, 1'b0);
   endtask

   task automatic test_skip();
      apply_reset();
      repeat (6) instr_cycle(0, 8'h00, 0, 1'b0);
      instr_cycle(0, 8'h00, 0, 1'b1);
      instr_cycle(0, 8'h00, 0, 1'b0);
      instr_cycle(3, 8'h60, 0, 1'b1);
      instr_cycle(0, 8'h00, 0, 1'b0);
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 40; n++) begin
         int bp, sp;
         bp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         sp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
         instr_cycle(bp, 8'($urandom), sp, 1'($urandom_range(0, 5) == 0));
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      repeat (2) instr_cycle(0, 8'h00, 0, 1'b0);
      tick();
      tick();
      branch_en = 1'b1;
      branch_addr = 8'h80;
      tick();
      branch_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({clk1, clk2, clk3, clk4, pmem_rd} !== 5'b0 || pc !== 8'h00 || inst_reg !== 8'h00 || flush !== 1'b1) begin
         $display("FAIL reset_mid: got en=%b pc=%h inst=%h flush=%b expected en=00000 pc=00 inst=00 flush=1",
                  {clk1, clk2, clk3, clk4, pmem_rd}, pc, inst_reg, flush);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      model_init();
      repeat (2) instr_cycle(0, 8'h00, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_pc_wrap();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      test_branch();
      test_branch_other_phases();
      test_back_to_back();
      test_stall();
      test_skip();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
